// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and AXI constants for the AXI read-port arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_rd_grant.sv
// Tie-break between IFU and LSU read requests plus the last_grant register.
// AXI_RD_ARB_RR_EN selects round-robin on ties; otherwise LSU has fixed priority.
module axi_rd_grant
  import axi_rd_arbiter_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   ifu_req,
  input  logic   lsu_req,
  input  logic   done,
  input  owner_e done_owner,
  output owner_e winner
);

  owner_e last_grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= OWN_LSU;
    end else if (done) begin
      last_grant <= done_owner;
    end
  end

`ifdef AXI_RD_ARB_RR_EN
  always_comb begin
    winner = OWN_IFU;
    if (ifu_req && lsu_req) begin
      winner = (last_grant == OWN_LSU) ? OWN_IFU : OWN_LSU;
    end else if (lsu_req) begin
      winner = OWN_LSU;
    end
  end
`else
  // Fixed priority: only the LSU request matters when deciding the winner.
  logic unused_grant_inputs;
  assign unused_grant_inputs = ^{ifu_req, last_grant};

  always_comb begin
    winner = lsu_req ? OWN_LSU : OWN_IFU;
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares the io_master AXI4 read port between IFU and LSU, one transaction at a time.
// Optional round-robin tie-break via AXI_RD_ARB_RR_EN (see axi_rd_grant).
//
// state  | meaning
// S_IDLE | sample requests; one-cycle arready pulse to the winner, latch payload
// S_ADDR | io_master_arvalid held with latched payload until arready
// S_DATA | R beats routed to owner until rlast (or beat count reaches arlen)
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [3:0]  IFU_ID = 4'd0,
  parameter logic [3:0]  LSU_ID = 4'd1
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,

  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,

  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [3:0]        io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rlast,
  input  logic [3:0]        io_master_rid,

  output logic              arb_err
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            winner;
  logic              gnt_q, gnt_d;
  logic              latch;
  logic              done;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [7:0]        beat_q, beat_d;
  logic              err_q, err_d;

  logic              own_is_lsu;
  logic              own_arvalid;
  logic              own_rready;
  logic [3:0]        own_id;
  logic              beat_acc;

  assign own_is_lsu  = (owner_q == OWN_LSU);
  assign own_arvalid = own_is_lsu ? lsu_arvalid : ifu_arvalid;
  assign own_rready  = own_is_lsu ? lsu_rready  : ifu_rready;
  assign own_id      = own_is_lsu ? LSU_ID      : IFU_ID;
  assign beat_acc    = (state_q == S_DATA) && io_master_rvalid && own_rready;

  axi_rd_grant u_grant (
    .clock      (clock),
    .reset      (reset),
    .ifu_req    (ifu_arvalid),
    .lsu_req    (lsu_arvalid),
    .done       (done),
    .done_owner (owner_q),
    .winner     (winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IFU;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      if (latch) begin
        addr_q <= own_is_lsu ? lsu_araddr : ifu_araddr;
        len_q  <= own_is_lsu ? lsu_arlen  : ifu_arlen;
        size_q <= own_is_lsu ? lsu_arsize : ifu_arsize;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = 1'b0;
    latch   = 1'b0;
    done    = 1'b0;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        // gnt_q marks the arready cycle; a requester that withdrew gets nothing.
        if (gnt_q) begin
          if (own_arvalid) begin
            latch   = 1'b1;
            beat_d  = '0;
            state_d = S_ADDR;
          end
        end else if (ifu_arvalid || lsu_arvalid) begin
          gnt_d   = 1'b1;
          owner_d = winner;
        end
      end
      S_ADDR: begin
        if (io_master_arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (beat_acc) begin
          beat_d = beat_q + 8'd1;
          if (io_master_rid != own_id)                  err_d = 1'b1;
          if (io_master_rlast && (beat_q != len_q))     err_d = 1'b1;
          if (!io_master_rlast && (beat_q == len_q))    err_d = 1'b1;
          if (io_master_rlast || (beat_q == len_q)) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ifu_arready = gnt_q && !own_is_lsu && ifu_arvalid;
  assign lsu_arready = gnt_q &&  own_is_lsu && lsu_arvalid;

  assign io_master_arvalid = (state_q == S_ADDR);
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = own_id;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = BURST_INCR;
  assign io_master_rready  = (state_q == S_DATA) && own_rready;

  assign ifu_rvalid = (state_q == S_DATA) && !own_is_lsu && io_master_rvalid;
  assign lsu_rvalid = (state_q == S_DATA) &&  own_is_lsu && io_master_rvalid;
  assign ifu_rdata  = io_master_rdata;
  assign ifu_rresp  = io_master_rresp;
  assign ifu_rlast  = io_master_rlast;
  assign lsu_rdata  = io_master_rdata;
  assign lsu_rresp  = io_master_rresp;
  assign lsu_rlast  = io_master_rlast;

  assign arb_err = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter; honours AXI_RD_ARB_RR_EN for tie order.
module tb_axi_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        ifu_arvalid = 1'b0, ifu_arready;
  logic [31:0] ifu_araddr = '0;
  logic [7:0]  ifu_arlen = '0;
  logic [2:0]  ifu_arsize = '0;
  logic        ifu_rvalid, ifu_rready = 1'b1;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rlast;

  logic        lsu_arvalid = 1'b0, lsu_arready;
  logic [31:0] lsu_araddr = '0;
  logic [7:0]  lsu_arlen = '0;
  logic [2:0]  lsu_arsize = '0;
  logic        lsu_rvalid, lsu_rready = 1'b1;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rlast;

  logic        io_master_arvalid, io_master_arready = 1'b0;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rvalid = 1'b0, io_master_rready;
  logic [31:0] io_master_rdata = '0;
  logic [1:0]  io_master_rresp = '0;
  logic        io_master_rlast = 1'b0;
  logic [3:0]  io_master_rid = '0;
  logic        arb_err;

  int n_chk = 0;
  int n_err = 0;

`ifdef AXI_RD_ARB_RR_EN
  localparam bit FIRST_LSU = 1'b0;
`else
  localparam bit FIRST_LSU = 1'b1;
`endif

  axi_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid),
    .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst), .io_master_rvalid(io_master_rvalid),
    .io_master_rready(io_master_rready), .io_master_rdata(io_master_rdata),
    .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
    .io_master_rid(io_master_rid), .arb_err(arb_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic last,
                      input logic [1:0] resp);
    io_master_rvalid = 1'b1;
    io_master_rid    = id;
    io_master_rdata  = data;
    io_master_rlast  = last;
    io_master_rresp  = resp;
    #1;
  endtask

  task automatic addr_accept();
    io_master_arready = 1'b1;
    tick();
    io_master_arready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_ifu_arready", ifu_arready, 0);
    check("rst_lsu_arready", lsu_arready, 0);
    check("rst_io_arvalid", io_master_arvalid, 0);
    check("rst_io_rready", io_master_rready, 0);
    check("rst_araddr", io_master_araddr, 0);
    check("rst_arid", io_master_arid, 0);
    check("rst_err", arb_err, 0);

    // IFU alone, single beat
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd0; ifu_arsize = 3'd2;
    #1;
    check("t1_arready_early", ifu_arready, 0);
    tick();
    check("t1_ifu_arready", ifu_arready, 1);
    check("t1_lsu_arready", lsu_arready, 0);
    tick();
    ifu_arvalid = 1'b0;
    #1;
    check("t1_arready_pulse", ifu_arready, 0);
    check("t1_io_arvalid", io_master_arvalid, 1);
    check("t1_araddr", io_master_araddr, 32'h8000_0000);
    check("t1_arid", io_master_arid, 0);
    check("t1_arsize", io_master_arsize, 2);
    check("t1_arburst", io_master_arburst, 1);
    addr_accept();
    check("t1_arvalid_drop", io_master_arvalid, 0);
    beat(4'd0, 32'h0000_0413, 1'b1, 2'b00);
    check("t1_ifu_rvalid", ifu_rvalid, 1);
    check("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    check("t1_lsu_rvalid", lsu_rvalid, 0);
    check("t1_io_rready", io_master_rready, 1);
    tick();
    io_master_rvalid = 1'b0;
    #1;
    check("t1_idle_rready", io_master_rready, 0);
    check("t1_err", arb_err, 0);

    // Simultaneous requests
    do_reset();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0004; ifu_arlen = 8'd0;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000; lsu_arlen = 8'd0; lsu_arsize = 3'd2;
    tick();
    check("t2_lsu_arready1", lsu_arready, FIRST_LSU);
    check("t2_ifu_arready1", ifu_arready, !FIRST_LSU);
    tick();
    if (FIRST_LSU) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    #1;
    check("t2_arid1", io_master_arid, FIRST_LSU ? 1 : 0);
    check("t2_araddr1", io_master_araddr, FIRST_LSU ? 32'h8000_1000 : 32'h8000_0004);
    check("t2_loser_wait_addr", FIRST_LSU ? ifu_arready : lsu_arready, 0);
    addr_accept();
    check("t2_loser_wait_data", FIRST_LSU ? ifu_arready : lsu_arready, 0);
    beat(FIRST_LSU ? 4'd1 : 4'd0, 32'hAAAA_5555, 1'b1, 2'b00);
    check("t2_win_rvalid", FIRST_LSU ? lsu_rvalid : ifu_rvalid, 1);
    check("t2_lose_rvalid", FIRST_LSU ? ifu_rvalid : lsu_rvalid, 0);
    tick();
    io_master_rvalid = 1'b0;
    #1;
    check("t2_idle_gap", FIRST_LSU ? ifu_arready : lsu_arready, 0);
    tick();
    check("t2_loser_arready", FIRST_LSU ? ifu_arready : lsu_arready, 1);
    tick();
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    #1;
    check("t2_arid2", io_master_arid, FIRST_LSU ? 0 : 1);
    check("t2_araddr2", io_master_araddr, FIRST_LSU ? 32'h8000_0004 : 32'h8000_1000);
    addr_accept();
    beat(FIRST_LSU ? 4'd0 : 4'd1, 32'h1234_5678, 1'b1, 2'b10);
    check("t2_rresp_fwd", FIRST_LSU ? ifu_rresp : lsu_rresp, 2'b10);
    check("t2_rdata2", FIRST_LSU ? ifu_rdata : lsu_rdata, 32'h1234_5678);
    tick();
    io_master_rvalid = 1'b0;
    #1;
    check("t2_slverr_no_err", arb_err, 0);

    // LSU burst arlen=3, rlast arrives early on beat 2
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000; lsu_arlen = 8'd3;
    tick();
    check("t3_lsu_arready", lsu_arready, 1);
    tick();
    lsu_arvalid = 1'b0;
    #1;
    check("t3_arlen", io_master_arlen, 3);
    addr_accept();
    for (int i = 0; i < 2; i++) begin
      beat(4'd1, 32'h100 + i, 1'b0, 2'b00);
      tick();
    end
    check("t3_err_before", arb_err, 0);
    beat(4'd1, 32'h102, 1'b1, 2'b00);
    check("t3_lsu_rlast", lsu_rlast, 1);
    tick();
    #1;
    check("t3_err_early_last", arb_err, 1);
    check("t3_idle_rvalid", lsu_rvalid, 0);
    check("t3_idle_rready", io_master_rready, 0);
    io_master_rvalid = 1'b0;
    do_reset();
    check("t3_err_cleared", arb_err, 0);

    // arlen=1 with missing rlast: beat 1 treated as last
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_3000; lsu_arlen = 8'd1;
    tick();
    tick();
    lsu_arvalid = 1'b0;
    addr_accept();
    beat(4'd1, 32'h200, 1'b0, 2'b00);
    tick();
    check("t4_err_mid", arb_err, 0);
    beat(4'd1, 32'h201, 1'b0, 2'b00);
    tick();
    #1;
    check("t4_err_nolast", arb_err, 1);
    check("t4_back_idle", io_master_rready, 0);
    io_master_rvalid = 1'b0;
    do_reset();

    // rid mismatch while LSU owns
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_4000; lsu_arlen = 8'd0;
    tick();
    tick();
    lsu_arvalid = 1'b0;
    addr_accept();
    beat(4'd0, 32'hDEAD_BEEF, 1'b1, 2'b00);
    check("t5_lsu_rvalid", lsu_rvalid, 1);
    check("t5_lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
    check("t5_ifu_rvalid", ifu_rvalid, 0);
    tick();
    io_master_rvalid = 1'b0;
    #1;
    check("t5_err_rid", arb_err, 1);
    do_reset();

    // Requester withdraws before grant
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_5000; ifu_arlen = 8'd0;
    tick();
    ifu_arvalid = 1'b0;
    #1;
    check("t6_withdraw_arready", ifu_arready, 0);
    tick();
    check("t6_no_addr", io_master_arvalid, 0);
    tick();
    check("t6_still_idle", io_master_arvalid, 0);

    // Reset in the middle of a burst
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_6000; ifu_arlen = 8'd1;
    tick();
    tick();
    ifu_arvalid = 1'b0;
    addr_accept();
    beat(4'd1, 32'h300, 1'b0, 2'b00);
    tick();
    check("t7_err_set", arb_err, 1);
    beat(4'd0, 32'h301, 1'b0, 2'b00);
    check("t7_rvalid_pre", ifu_rvalid, 1);
    reset = 1'b1;
    #1;
    check("t7_rvalid_rst", ifu_rvalid, 0);
    check("t7_rready_rst", io_master_rready, 0);
    check("t7_err_rst", arb_err, 0);
    check("t7_arvalid_rst", io_master_arvalid, 0);
    tick();
    io_master_rvalid = 1'b0;
    reset = 1'b0;
    tick();
    check("t7_idle_after", io_master_rready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI4 read port (io_master_ar*/r*) between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the ysyx_24080008 core.
- Sits between both requesters and the io_master AR/R channels; write channels bypass it (LSU-only).
- Grants one read transaction at a time, holds the grant until the last R beat is accepted, and routes R beats back to the owner.
- Tracks burst length and flags protocol errors.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- IFU_ID, 4'd0, arid driven for IFU transactions.
- LSU_ID, 4'd1, arid driven for LSU transactions.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- ifu_arvalid/ifu_arready  in/out  1/1  IFU AR handshake.
- ifu_araddr/ifu_arlen/ifu_arsize  in  ADDR_W/8/3  IFU AR payload.
- ifu_rvalid/ifu_rready  out/in  1/1  IFU R handshake.
- ifu_rdata/ifu_rresp/ifu_rlast  out  DATA_W/2/1  IFU R payload.
- lsu_arvalid/lsu_arready  in/out  1/1  LSU AR handshake.
- lsu_araddr/lsu_arlen/lsu_arsize  in  ADDR_W/8/3  LSU AR payload.
- lsu_rvalid/lsu_rready  out/in  1/1  LSU R handshake.
- lsu_rdata/lsu_rresp/lsu_rlast  out  DATA_W/2/1  LSU R payload.
- io_master_arvalid/io_master_arready  out/in  1/1  downstream AR handshake.
- io_master_araddr/arid/arlen/arsize/arburst  out  ADDR_W/4/8/3/2  downstream AR payload.
- io_master_rvalid/io_master_rready  in/out  1/1  downstream R handshake.
- io_master_rdata/rresp/rlast/rid  in  DATA_W/2/1/4  downstream R payload.
- arb_err  out  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Reset state:
  - FSM in IDLE, owner=IFU, last_grant=LSU.
  - All *_arvalid, *_arready, *_rvalid and io_master_rready are 0.
  - Latched payload regs are 0; beat counter is 0; arb_err is 0.
- FSM IDLE:
  - Sample ifu_arvalid and lsu_arvalid.
  - Fixed priority: LSU beats IFU when both are asserted in the same cycle. This prevents a load/store starving behind fetch.
  - On a grant: pulse the winner's *_arready for exactly one cycle (the requester handshake completes there).
  - In the same cycle latch araddr/arlen/arsize and record owner; beat counter <= 0.
  - Next state ADDR.
- FSM ADDR:
  - io_master_arvalid=1, driven from the latched regs.
  - arid=owner ID; arburst=2'b01 (INCR).
  - On io_master_arready goto DATA. Payload stays stable until then.
- FSM DATA:
  - io_master_rready = owner's *_rready (combinational).
  - Owner's *_rvalid = io_master_rvalid; rdata/rresp/rlast are passed through combinationally.
  - Non-owner rvalid=0.
  - Each accepted beat (rvalid&rready) increments the beat counter.
  - On an accepted beat with rlast=1: goto IDLE and set last_grant=owner.
- Latency:
  - Grant in the cycle after arvalid is seen (one IDLE cycle).
  - ARVALID reaches io_master in the cycle after the grant.
  - Minimum back-to-back turnaround: 1 IDLE cycle between an rlast beat and the next arvalid.
- Error detection (each sets arb_err sticky until reset; routing is unaffected):
  - Accepted beat with rid != owner ID.
  - rlast asserted on beat != latched arlen.
  - Beat counter == arlen accepted without rlast. In this case treat the beat as last and return to IDLE.
- Boundaries:
  - A requester dropping arvalid before the grant is legal; no grant is issued.
  - A new request during ADDR/DATA waits; its arready stays 0.
  - rresp != OKAY is forwarded unchanged and is not an arbiter error.
  - Reset mid-burst aborts immediately to the reset state.

Optional Feature:
- Macro AXI_RD_ARB_RR_EN.
- Defined: round-robin. On a tie, grant the requester that is not last_grant.
- Undefined: fixed LSU priority, and last_grant is unused.

Decomposition:
- Shared package holds:
  - Owner enum (OWN_IFU, OWN_LSU).
  - FSM state enum (S_IDLE, S_ADDR, S_DATA).
  - AXI constants BURST_INCR=2'b01 and RESP_OKAY=2'b00.
- One sub-module: axi_rd_grant, a combinational tie-break plus the last_grant register.

Test Plan:
- IFU alone, araddr=0x80000000, arlen=0 → ifu_arready pulses 1 cycle later; io_master_araddr=0x80000000, arid=0. One beat rdata=0x00000413 reaches ifu_rdata; FSM back to IDLE.
- IFU and LSU assert in the same cycle (LSU addr 0x80001000) → LSU granted first with arid=1; IFU granted after the LSU rlast beat, with 1 IDLE cycle gap.
- Same as the previous test with AXI_RD_ARB_RR_EN, and last_grant=LSU → IFU granted first.
- LSU burst arlen=3 with rlast on beat 2 → arb_err=1, FSM returns to IDLE.
- Response rid=0 while owner is LSU → arb_err=1; data still delivered to LSU.
- reset asserted during DATA with io_master_rvalid=1 → all valids/readies drop asynchronously; arb_err=0; FSM in IDLE.
